// File: rtl/bist_response_analyzer.sv
// BIST response analyzer: counts patterns and failures, detects upstream stalls, issues a session verdict.
// Optional MISR signature compaction is enabled by defining BIST_MISR_EN.
module bist_response_analyzer #(
    parameter int         NUM_PATTERNS = 15,
    parameter int         PAT_W        = 5,
    parameter int         TIMEOUT      = 32,
    parameter logic [7:0] GOLDEN_SIG   = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pass_in,
    input  logic             fail_in,
    input  logic             resp_in,
    output logic             busy,
    output logic             done,
    output logic             verdict_pass,
    output logic             timeout,
    output logic [PAT_W-1:0] fail_count,
    output logic [PAT_W-1:0] first_fail_idx,
    output logic [PAT_W-1:0] pattern_count,
    output logic [7:0]       signature
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [IDLE_W-1:0] idle_count;
    logic [IDLE_W-1:0] idle_inc;
    logic [PAT_W-1:0]  pattern_inc;
    logic [PAT_W-1:0]  fail_next;
    logic              accept;
    logic              bubble;
    logic              last_sample;
    logic              idle_expire;
    logic              enter_done;
    logic              sig_ok;

    assign idle_inc    = idle_count + 1'b1;
    assign pattern_inc = pattern_count + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = COLLECT;
            COLLECT: begin
                if (start)           state_next = COLLECT;
                else if (enter_done) state_next = DONE;
            end
            DONE:    if (start) state_next = COLLECT;
            default: state_next = IDLE;
        endcase
    end

    // A sample in the same cycle as start is discarded: start always wins.
    always_comb begin
        accept      = (state == COLLECT) && !start && (pass_in || fail_in);
        bubble      = (state == COLLECT) && !start && !(pass_in || fail_in);
        last_sample = accept && (pattern_inc == PAT_W'(NUM_PATTERNS));
        idle_expire = bubble && (idle_inc == IDLE_W'(TIMEOUT));
        enter_done  = last_sample || idle_expire;
        fail_next   = fail_count;
        if (accept && fail_in && (fail_count != '1)) begin
            fail_next = fail_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy           <= 1'b0;
            done           <= 1'b0;
            verdict_pass   <= 1'b0;
            timeout        <= 1'b0;
            fail_count     <= '0;
            pattern_count  <= '0;
            first_fail_idx <= '1;
            idle_count     <= '0;
        end else if (start) begin
            busy           <= 1'b1;
            done           <= 1'b0;
            verdict_pass   <= 1'b0;
            timeout        <= 1'b0;
            fail_count     <= '0;
            pattern_count  <= '0;
            first_fail_idx <= '1;
            idle_count     <= '0;
        end else if (state == COLLECT) begin
            if (accept) begin
                pattern_count <= pattern_inc;
                fail_count    <= fail_next;
                idle_count    <= '0;
                if (fail_in && (first_fail_idx == '1)) begin
                    first_fail_idx <= pattern_count;
                end
            end else begin
                idle_count <= idle_inc;
            end
            if (enter_done) begin
                busy         <= 1'b0;
                done         <= 1'b1;
                timeout      <= idle_expire;
                verdict_pass <= (fail_next == '0) && !idle_expire && sig_ok;
            end
        end
    end

`ifdef BIST_MISR_EN
    logic [7:0] misr_next;

    // MISR polynomial x^8+x^4+x^3+x^2+1, response injected at bit 0.
    always_comb begin
        misr_next = {signature[6:4],
                     signature[3] ^ signature[7],
                     signature[2] ^ signature[7],
                     signature[1] ^ signature[7],
                     signature[0],
                     signature[7] ^ resp_in};
        sig_ok = accept ? (misr_next == GOLDEN_SIG) : (signature == GOLDEN_SIG);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            signature <= 8'h01;
        end else if (start) begin
            signature <= 8'h01;
        end else if (accept) begin
            signature <= misr_next;
        end
    end
`else
    logic       unused_resp;
    logic [7:0] unused_golden;

    assign unused_resp   = resp_in;
    assign unused_golden = GOLDEN_SIG;
    assign signature     = 8'h00;
    assign sig_ok        = 1'b1;
`endif

endmodule

// File: doc/bist_response_analyzer.md
Name: bist_response_analyzer

Overview:
- Downstream of the CLB BIST top level: consumes the per-pattern pass/fail strobes and the registered CUT response bit.
- Counts applied patterns and failing patterns, records the index of the first failing pattern, and detects a stalled upstream stage via a timeout.
- Issues a single end-of-session verdict to the test controller.
- Optionally compacts the response stream into an 8-bit MISR signature and compares it against a golden value.

Parameters:
- NUM_PATTERNS, 15, valid samples per session (full 4-bit LFSR sequence); range 1..2^PAT_W-1
- PAT_W, 5, width of pattern counter, fail counter and first-fail index
- TIMEOUT, 32, max consecutive cycles without a valid sample in COLLECT; range >=1
- GOLDEN_SIG, 8'h00, expected MISR signature (used only with BIST_MISR_EN)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins (or restarts) a session
- pass_in  input  1  upstream pass strobe for the current pattern
- fail_in  input  1  upstream fail strobe for the current pattern
- resp_in  input  1  registered CUT response bit, same-cycle aligned with pass_in/fail_in
- busy  output  1  high while in COLLECT
- done  output  1  high in DONE until the next start
- verdict_pass  output  1  valid when done=1; 1 = session passed
- timeout  output  1  session ended by timeout (sticky until start)
- fail_count  output  PAT_W  failing samples, saturating
- first_fail_idx  output  PAT_W  0-based index of the first failing sample; all-ones if none
- pattern_count  output  PAT_W  valid samples consumed this session
- signature  output  8  MISR contents (zero without BIST_MISR_EN)

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; busy=0, done=0, verdict_pass=0, timeout=0; fail_count=0; pattern_count=0; first_fail_idx=all-ones; signature=8'h01 (with BIST_MISR_EN) or 0 (without). Deassertion is taken synchronously at the next clk edge.
- All outputs are registered.
- Sample classification, per cycle in COLLECT:
  - pass_in=1, fail_in=0: valid pass.
  - fail_in=1, pass_in=0: valid fail.
  - both 1: protocol error, counted as a valid fail.
  - both 0: bubble; not counted; the idle counter increments.
- States: IDLE, COLLECT, DONE.
- IDLE -> COLLECT on start. On entry:
  - counters and timeout cleared; first_fail_idx set to all-ones; MISR seeded to 8'h01; idle counter cleared.
  - busy=1 from the cycle after start.
- COLLECT, on each valid sample:
  - pattern_count increments.
  - On a fail, fail_count increments, saturating at 2^PAT_W-1.
  - If first_fail_idx is all-ones at a fail, it captures the pre-increment pattern_count.
  - MISR shifts once using resp_in.
  - The idle counter clears.
- COLLECT -> DONE:
  - On the cycle the incremented pattern_count equals NUM_PATTERNS; done=1 and busy=0 the following cycle, i.e. 1-cycle latency from the last valid sample.
  - When the idle counter reaches TIMEOUT; timeout=1 and verdict_pass=0.
- DONE: outputs frozen; inputs ignored except start. start -> COLLECT with the full clear above.
- start in COLLECT restarts the session with the same clear. A sample arriving in the same cycle as start is discarded.
- Samples arriving in IDLE or DONE are ignored.
- verdict_pass = (fail_count==0) & ~timeout, plus (signature==GOLDEN_SIG) with BIST_MISR_EN. Registered on entry to DONE.
- MISR (x^8+x^4+x^3+x^2+1), on each valid sample:
  - n[0] = s[7]^resp_in
  - n[1] = s[0]
  - n[i] = s[i-1]^s[7] for i = 2, 3, 4
  - n[i] = s[i-1] for i = 5..7
- Asynchronous reset mid-session returns to IDLE immediately; no partial verdict is retained.

Optional Feature:
- BIST_MISR_EN defined: MISR register instantiated; signature output live; signature match gates verdict_pass.
- BIST_MISR_EN undefined: no MISR logic; signature tied to 8'h00; resp_in unused; verdict depends only on fail_count and timeout.

Test Plan:
- Reset with rst=0 for 3 cycles, then start, then 15 cycles of pass_in=1 -> done=1 one cycle after the 15th sample; pattern_count=15, fail_count=0, first_fail_idx=5'h1F, verdict_pass=1 (golden set to the simulated signature when BIST_MISR_EN is defined).
- As above, but fail_in=1 on samples 4 and 9 (0-based), with bubbles between every sample -> fail_count=2, first_fail_idx=4, pattern_count=15, verdict_pass=0.
- start, 3 passes, then pass_in=fail_in=0 for 32 cycles -> timeout=1, done=1, pattern_count=3, verdict_pass=0.
- pass_in=fail_in=1 on sample 0, remaining samples pass -> fail_count=1, first_fail_idx=0, verdict_pass=0.
- start, 7 samples, start again, then 15 passes -> pattern_count=15 and fail_count=0 (first 7 discarded); rst pulsed low mid-session -> all outputs return to reset values asynchronously.
- BIST_MISR_EN defined, resp_in=1 on all 15 samples from seed 8'h01 -> signature equals the bench's reference-model MISR value; flipping resp_in on one sample -> signature differs and verdict_pass=0.
